// File: rtl/adau_cfg_pkg.sv
// Shared types and constants for the ADAU1761 control-port sequencer.
package adau_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    LOAD,
    SHIFT,
    GAP
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } reg_wr_t;

  localparam logic [7:0] CHIP_ADDR   = 8'h00;
  localparam int         FRAME_W     = 32;
  localparam int         WAKE_PULSES = 3;

  // Chip-address byte carries R/W=0 in its LSB, so every frame is a write.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [15:0] addr,
                                                     input logic [7:0]  data);
    return {CHIP_ADDR, addr, data};
  endfunction

endpackage

// File: rtl/adau_init_rom.sv
// Boot-time register table for the codec: clocking, serial port, DAC/mixer routing.
// Purely combinational lookup; indexes beyond the table return a harmless zero write.
module adau_init_rom
  import adau_cfg_pkg::*;
(
  input  logic [7:0] index,
  output reg_wr_t    entry
);

  always_comb begin
    entry = '{addr: 16'h0000, data: 8'h00};
    case (index)
      8'd0:  entry = '{addr: 16'h4000, data: 8'h01};
      8'd1:  entry = '{addr: 16'h4015, data: 8'h01};
      8'd2:  entry = '{addr: 16'h4016, data: 8'h00};
      8'd3:  entry = '{addr: 16'h4017, data: 8'h00};
      8'd4:  entry = '{addr: 16'h401C, data: 8'h21};
      8'd5:  entry = '{addr: 16'h401E, data: 8'h41};
      8'd6:  entry = '{addr: 16'h4023, data: 8'hE7};
      8'd7:  entry = '{addr: 16'h4024, data: 8'hE7};
      8'd8:  entry = '{addr: 16'h4025, data: 8'hE7};
      8'd9:  entry = '{addr: 16'h4026, data: 8'hE7};
      8'd10: entry = '{addr: 16'h4029, data: 8'h03};
      8'd11: entry = '{addr: 16'h402A, data: 8'h03};
      8'd12: entry = '{addr: 16'h402B, data: 8'h00};
      8'd13: entry = '{addr: 16'h40F2, data: 8'h01};
      8'd14: entry = '{addr: 16'h40F9, data: 8'h7F};
      8'd15: entry = '{addr: 16'h40FA, data: 8'h03};
      default: entry = '{addr: 16'h0000, data: 8'h00};
    endcase
  end

endmodule

// File: rtl/adau_spi_cfg_ctrl.sv
// ADAU1761 control-port sequencer: wake into SPI mode, stream the init table, then host writes.
// Host accepted 1 cycle -> CLATCH low; req_ready held low while busy or before init completes.
module adau_spi_cfg_ctrl
  import adau_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 16,
  parameter int NUM_INIT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        busy,
  output logic        init_done,
  output logic        ac_clatch,
  output logic        ac_cdata,
  output logic        ac_cclk
);

  localparam int             CNT_W     = 16;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [4:0]     WAKE_LAST = 5'(2 * WAKE_PULSES - 1);
  localparam logic [4:0]     BIT_LAST  = 5'(FRAME_W - 1);
  localparam logic [7:0]     LAST_IDX  = 8'(NUM_INIT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [4:0]         bit_q, bit_d;
  logic [7:0]         idx_q, idx_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic               src_host_q, src_host_d;
  logic               init_done_q, init_done_d;
  logic               clatch_q, clatch_d;
  logic               cclk_q, cclk_d;

  logic [7:0]         rom_idx;
  reg_wr_t            rom_ent;
  logic [FRAME_W-1:0] rom_frame;
  logic [FRAME_W-1:0] host_frame;

  // The ROM is addressed by the entry about to be loaded, not the one just sent.
  assign rom_idx    = (state_q == GAP) ? idx_q + 8'd1 : 8'd0;
  assign rom_frame  = make_frame(rom_ent.addr, rom_ent.data);
  assign host_frame = make_frame(req_addr, req_data);

  adau_init_rom u_rom (
    .index (rom_idx),
    .entry (rom_ent)
  );

  assign req_ready = (state_q == IDLE) && init_done_q && !start;
  assign busy      = (state_q != IDLE);
  assign init_done = init_done_q;
  assign ac_clatch = clatch_q;
  assign ac_cclk   = cclk_q;
  assign ac_cdata  = sr_q[FRAME_W-1];

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    idx_d       = idx_q;
    sr_d        = sr_q;
    src_host_d  = src_host_q;
    init_done_d = init_done_q;
    clatch_d    = clatch_q;
    cclk_d      = cclk_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WAKE;
          init_done_d = 1'b0;
          idx_d       = 8'd0;
          div_d       = '0;
          bit_d       = '0;
          clatch_d    = 1'b0;
        end else if (req_valid && req_ready) begin
          state_d    = LOAD;
          src_host_d = 1'b1;
          sr_d       = host_frame;
          clatch_d   = 1'b0;
        end
      end

      // bit_q counts CLATCH half-periods here; odd half-periods are high.
      WAKE: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == WAKE_LAST) begin
            if (NUM_INIT == 0) begin
              state_d     = IDLE;
              init_done_d = 1'b1;
            end else begin
              state_d    = LOAD;
              src_host_d = 1'b0;
              sr_d       = rom_frame;
              clatch_d   = 1'b0;
            end
          end else begin
            bit_d    = bit_q + 5'd1;
            clatch_d = ~clatch_q;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      LOAD: begin
        state_d = SHIFT;
        div_d   = '0;
        bit_d   = '0;
        cclk_d  = 1'b0;
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!cclk_q) begin
            cclk_d = 1'b1;
          end else if (bit_q == BIT_LAST) begin
            state_d  = GAP;
            clatch_d = 1'b1;
            sr_d     = '0;
          end else begin
            bit_d  = bit_q + 5'd1;
            sr_d   = {sr_q[FRAME_W-2:0], 1'b0};
            cclk_d = 1'b0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      GAP: begin
        if (div_q == GAP_LAST) begin
          div_d = '0;
          if (src_host_q) begin
            state_d = IDLE;
          end else if (idx_q == LAST_IDX) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d  = LOAD;
            idx_d    = idx_q + 8'd1;
            sr_d     = rom_frame;
            clatch_d = 1'b0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      idx_q       <= '0;
      sr_q        <= '0;
      src_host_q  <= 1'b0;
      init_done_q <= 1'b0;
      clatch_q    <= 1'b1;
      cclk_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      idx_q       <= idx_d;
      sr_q        <= sr_d;
      src_host_q  <= src_host_d;
      init_done_q <= init_done_d;
      clatch_q    <= clatch_d;
      cclk_q      <= cclk_d;
    end
  end

endmodule

// File: tb/tb_adau_spi_cfg_ctrl.sv
// Scoreboarded bench: stimulus pushes expected CLATCH-low windows, a monitor decodes the pins.
module tb_adau_spi_cfg_ctrl;

  localparam int D         = 2;
  localparam int G         = 4;
  localparam int N         = 3;
  localparam int FRAME_LOW = 1 + 64 * D;
  localparam int BUDGET    = 5000;

  typedef struct {
    int          nbits;
    logic [31:0] bits;
    int          low;
    int          high;   // -1: preceding high time not constrained
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, start = 1'b0, req_valid = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_data = '0;
  logic        req_ready, busy, init_done, ac_clatch, ac_cdata, ac_cclk;

  logic        z_start = 1'b0, z_req_valid = 1'b0;
  logic [15:0] z_req_addr = '0;
  logic [7:0]  z_req_data = '0;
  logic        z_req_ready, z_busy, z_init_done, z_clatch, z_cdata, z_cclk;

  adau_spi_cfg_ctrl #(.CLK_DIV(D), .GAP_CYCLES(G), .NUM_INIT(N)) dut (
    .clk(clk), .reset(reset), .start(start),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .busy(busy), .init_done(init_done),
    .ac_clatch(ac_clatch), .ac_cdata(ac_cdata), .ac_cclk(ac_cclk)
  );

  adau_spi_cfg_ctrl #(.CLK_DIV(D), .GAP_CYCLES(G), .NUM_INIT(0)) dut_z (
    .clk(clk), .reset(reset), .start(z_start),
    .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_addr(z_req_addr), .req_data(z_req_data),
    .busy(z_busy), .init_done(z_init_done),
    .ac_clatch(z_clatch), .ac_cdata(z_cdata), .ac_cclk(z_cclk)
  );

  int    vectors = 0;
  int    miscompares = 0;
  item_t exp_q[$];
  bit    flush = 1'b0;

  logic [15:0] tab_addr [N] = '{16'h4000, 16'h4015, 16'h4016};
  logic [7:0]  tab_data [N] = '{8'h01, 8'h01, 8'h00};

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Reference: three wake pulses of D low / D high, then each table entry as a 32-bit write.
  function automatic void push_start();
    item_t it;
    for (int p = 0; p < 3; p++) begin
      it.nbits = 0; it.bits = '0; it.low = D; it.high = (p == 0) ? -1 : D;
      exp_q.push_back(it);
    end
    for (int i = 0; i < N; i++) begin
      it.nbits = 32; it.bits = {8'h00, tab_addr[i], tab_data[i]};
      it.low = FRAME_LOW; it.high = (i == 0) ? D : G;
      exp_q.push_back(it);
    end
  endfunction

  // Monitor: each CLATCH-low window is one item; CDATA is taken on CCLK rising edges.
  logic        pc = 1'b1, pk = 1'b1;
  int          lowlen = 0, highlen = 0, nb = 0, hi_before = 0;
  logic [31:0] sh = '0;
  item_t       e;

  always @(negedge clk) begin
    if (ac_clatch === 1'b0) begin
      if (pc === 1'b1) begin
        lowlen = 0; nb = 0; sh = '0; hi_before = highlen;
      end
      lowlen++;
      if (ac_cclk === 1'b1 && pk === 1'b0) begin
        sh = {sh[30:0], ac_cdata};
        nb++;
      end
    end else begin
      if (pc === 1'b0 && !flush) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_window: got bits=%0d data=%h low=%0d, expected nothing", nb, sh, lowlen);
        end else begin
          e = exp_q.pop_front();
          if (nb != e.nbits || sh !== e.bits || lowlen != e.low || (e.high >= 0 && hi_before != e.high)) begin
            miscompares++;
            $display("FAIL window: got bits=%0d data=%h low=%0d high=%0d, expected bits=%0d data=%h low=%0d high=%0d",
                     nb, sh, lowlen, hi_before, e.nbits, e.bits, e.low, e.high);
          end
        end
      end
      if (pc === 1'b0) highlen = 0;
      highlen++;
    end
    pc = ac_clatch;
    pk = ac_cclk;
  end

  task automatic do_start(input bit with_req, input logic [15:0] a, input logic [7:0] d);
    int k;
    @(negedge clk);
    start = 1'b1;
    if (with_req) begin
      req_valid = 1'b1; req_addr = a; req_data = d;
    end
    push_start();
    #1 chk("ready_low_on_start", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("wake_clatch_fall", ac_clatch, 0);
    chk("busy_in_wake", busy, 1);
    chk("init_done_cleared", init_done, 0);
    k = 1;
    while (!init_done && k <= BUDGET) begin
      @(negedge clk);
      k++;
    end
    chk("start_to_init_done", k, 6 * D + N * (1 + 64 * D + G) + 1);
  endtask

  // Call at a falling edge; returns at the falling edge where busy is low again.
  task automatic host_write(input logic [15:0] a, input logic [7:0] d, input bit expect_now);
    int n, k;
    item_t it;
    req_valid = 1'b1; req_addr = a; req_data = d;
    n = 0;
    #1;
    while (!req_ready && n <= BUDGET) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (expect_now) chk("accept_latency", n, 0);
    chk("ready_implies_init_done", init_done, 1);
    it.nbits = 32; it.bits = {8'h00, a, d}; it.low = FRAME_LOW; it.high = -1;
    exp_q.push_back(it);
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        req_valid = 1'b0;
        chk("accept_clatch_low", ac_clatch, 0);
        chk("busy_after_accept", busy, 1);
      end
    end while (busy && k <= BUDGET);
    chk("accept_to_idle", k, 2 + 64 * D + G);
  endtask

  task automatic check_idle_pins(input string tag);
    chk({tag, "_clatch"}, ac_clatch, 1);
    chk({tag, "_cclk"}, ac_cclk, 1);
    chk({tag, "_cdata"}, ac_cdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask

  initial begin
    int          k, falls, lows;
    logic        prevc;
    logic [15:0] ra;
    logic [7:0]  rd;

    repeat (3) @(negedge clk);
    check_idle_pins("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_before_init", req_ready, 0);

    // NUM_INIT=0 instance: wake pulses only.
    z_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    z_start = 1'b0;
    k = 1; falls = 0; lows = 0; prevc = 1'b1;
    while (z_busy && k <= BUDGET) begin
      if (!z_clatch && prevc) falls++;
      if (!z_cclk) lows++;
      prevc = z_clatch;
      @(negedge clk);
      k++;
    end
    chk("z_wake_len", k, 6 * D + 1);
    chk("z_init_done", z_init_done, 1);
    chk("z_clatch_pulses", falls, 3);
    chk("z_cclk_lows", lows, 0);
    chk("z_clatch_idle", z_clatch, 1);
    chk("z_cdata_idle", z_cdata, 0);

    // Request raised during init must wait for init_done.
    fork
      do_start(1'b0, 16'h0, 8'h0);
      begin
        repeat (3) @(negedge clk);
        host_write(16'h40A5, 8'h5A, 1'b0);
      end
    join

    host_write(16'h4015, 8'h01, 1'b1);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      ra = 16'($urandom);
      rd = 8'($urandom);
      host_write(ra, rd, 1'b1);
    end

    // start and req_valid together: start wins, request stays pending.
    do_start(1'b1, 16'h4123, 8'hC3);
    host_write(16'h4123, 8'hC3, 1'b1);

    // Reset in the middle of a frame.
    flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 16'hFFFF; req_data = 8'hFF;
    #1 chk("ready_before_abort", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (1 + 16 * 2 * D) @(negedge clk);
    chk("mid_frame_clatch", ac_clatch, 0);
    chk("mid_frame_cdata", ac_cdata, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle_pins("abort");
    exp_q.delete();
    repeat (2) @(negedge clk);
    flush = 1'b0;

    do_start(1'b0, 16'h0, 8'h0);
    ra = 16'($urandom);
    rd = 8'($urandom);
    host_write(ra, rd, 1'b1);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
